// File: rtl/conv_layer_controller.sv
// conv_layer_controller
//
// Sequences one output-channel group of a convolution layer: fetches the
// group bias, then issues one weight-buffer read for every incoming
// input-channel-group beat. The address walks base..base+G-1 and wraps. The
// MAC-side valid/last-channel strobes are the weight read strobes delayed by
// the weight-buffer latency. After the final pixel beat the pipeline drains
// and done pulses.
//
// Handshake: go is a request pulse that is only accepted in IDLE. bias_valid
// and pixel_valid are one-cycle qualifiers sampled on the rising clock edge.
// There is no back-pressure: every pixel_valid beat seen in CONV is consumed
// in that cycle.
//
// Optional build macro: CONV_CTRL_ASSERT_EN compiles in simulation-only
// protocol assertions. Without it the module has no checker logic.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   cfg_ci_groups [9:0]        input-channel groups per pixel (0 means 1)
//   cfg_output_group           output group index used for the bias read
//   cfg_wt_base_addr           weight base address for this group
//   go                         start pulse
//   busy, done                 run in progress / one-cycle completion pulse
//   bias_rd_en, bias_rd_group  bias read request and latched group index
//   bias_valid                 bias data returned
//   wt_rd_en, wt_rd_addr       weight read request and address
//   wt_data_ready              weight data ready (informational)
//   pixel_valid, last_pixel    input beat strobe / final beat of the image
//   conv_valid_in              MAC input valid
//   conv_last_channel          final channel group of a pixel
module conv_layer_controller #(
  parameter int WT_ADDR_WIDTH   = 12,
  parameter int BIAS_ADDR_WIDTH = 7,
  parameter int WT_LATENCY      = 3,
  parameter int DRAIN_CYCLES    = 7
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [9:0]                 cfg_ci_groups,
  input  logic [BIAS_ADDR_WIDTH-1:0] cfg_output_group,
  input  logic [WT_ADDR_WIDTH-1:0]   cfg_wt_base_addr,
  input  logic                       go,
  output logic                       busy,
  output logic                       done,
  output logic                       bias_rd_en,
  output logic [BIAS_ADDR_WIDTH-1:0] bias_rd_group,
  input  logic                       bias_valid,
  output logic                       wt_rd_en,
  output logic [WT_ADDR_WIDTH-1:0]   wt_rd_addr,
  input  logic                       wt_data_ready,
  input  logic                       pixel_valid,
  input  logic                       last_pixel,
  output logic                       conv_valid_in,
  output logic                       conv_last_channel
);

  localparam int DRAIN_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BIAS_REQ,
    S_BIAS_WAIT,
    S_CONV,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [9:0]                 ci_groups_q;
  logic [9:0]                 ci_cnt;
  logic [WT_ADDR_WIDTH-1:0]   wt_base_q;
  logic [BIAS_ADDR_WIDTH-1:0] bias_group_q;
  logic [DRAIN_W-1:0]         drain_cnt;
  logic                       wt_last_tag;
  logic [WT_LATENCY-1:0]      valid_pipe;
  logic [WT_LATENCY-1:0]      last_pipe;
  logic                       beat_accept;
  logic                       last_ch;
  logic                       drain_end;

  // Weight data readiness is implied by the fixed latency pipe.
  logic unused_wt_data_ready;
  assign unused_wt_data_ready = wt_data_ready;

  assign beat_accept = (state == S_CONV) && pixel_valid;
  assign last_ch     = (ci_cnt == (ci_groups_q - 10'd1));
  assign drain_end   = (drain_cnt == DRAIN_W'(DRAIN_CYCLES - 1));

  assign bias_rd_group     = bias_group_q;
  assign conv_valid_in     = valid_pipe[WT_LATENCY-1];
  assign conv_last_channel = valid_pipe[WT_LATENCY-1] & last_pipe[WT_LATENCY-1];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and state-decoded outputs
  always_comb begin
    state_nxt  = state;
    busy       = 1'b0;
    done       = 1'b0;
    bias_rd_en = 1'b0;
    case (state)
      S_IDLE: begin
        if (go) state_nxt = S_BIAS_REQ;
      end
      S_BIAS_REQ: begin
        busy       = 1'b1;
        bias_rd_en = 1'b1;
        state_nxt  = S_BIAS_WAIT;
      end
      S_BIAS_WAIT: begin
        busy = 1'b1;
        if (bias_valid) state_nxt = S_CONV;
      end
      S_CONV: begin
        busy = 1'b1;
        if (pixel_valid && last_pixel) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (drain_end) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Configuration latch, weight read issue and channel counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ci_groups_q  <= 10'd1;
      wt_base_q    <= '0;
      bias_group_q <= '0;
      ci_cnt       <= '0;
      wt_rd_en     <= 1'b0;
      wt_rd_addr   <= '0;
      wt_last_tag  <= 1'b0;
    end else begin
      if ((state == S_IDLE) && go) begin
        ci_groups_q  <= (cfg_ci_groups == 10'd0) ? 10'd1 : cfg_ci_groups;
        wt_base_q    <= cfg_wt_base_addr;
        bias_group_q <= cfg_output_group;
        ci_cnt       <= '0;
      end
      wt_rd_en    <= beat_accept;
      wt_last_tag <= beat_accept && last_ch;
      if (beat_accept) begin
        // Sum is deliberately truncated to the address width.
        wt_rd_addr <= wt_base_q + WT_ADDR_WIDTH'(ci_cnt);
        if (last_pixel || last_ch) begin
          ci_cnt <= '0;
        end else begin
          ci_cnt <= ci_cnt + 10'd1;
        end
      end
    end
  end

  // Drain counter: counts cycles spent in DRAIN, zero elsewhere
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drain_cnt <= '0;
    end else if (state == S_DRAIN) begin
      drain_cnt <= drain_cnt + DRAIN_W'(1);
    end else begin
      drain_cnt <= '0;
    end
  end

  // Latency pipes shift in every state so pulses issued late in CONV still
  // come out during DRAIN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_pipe <= '0;
      last_pipe  <= '0;
    end else begin
      valid_pipe <= {valid_pipe[WT_LATENCY-2:0], wt_rd_en};
      last_pipe  <= {last_pipe[WT_LATENCY-2:0], wt_last_tag};
    end
  end

`ifdef CONV_CTRL_ASSERT_EN
  a_go_while_busy: assert property (@(posedge clk) disable iff (!rst_n)
    !(go && busy));
  a_bias_one_cycle: assert property (@(posedge clk) disable iff (!rst_n)
    bias_rd_en |=> !bias_rd_en);
  a_last_needs_valid: assert property (@(posedge clk) disable iff (!rst_n)
    conv_last_channel |-> conv_valid_in);
  a_pixel_in_conv: assert property (@(posedge clk) disable iff (!rst_n)
    pixel_valid |-> (state == S_CONV));
`endif

endmodule

// File: tb/tb_conv_layer_controller.sv
// Testbench for conv_layer_controller: randomized runs compared against a
// beat-index reference model (address = base + beat mod G, last tag on
// beat mod G == G-1, MAC valid three cycles after each weight read).
module tb_conv_layer_controller;

  logic        clk;
  logic        rst_n;
  logic [9:0]  cfg_ci_groups;
  logic [6:0]  cfg_output_group;
  logic [11:0] cfg_wt_base_addr;
  logic        go;
  logic        busy;
  logic        done;
  logic        bias_rd_en;
  logic [6:0]  bias_rd_group;
  logic        bias_valid;
  logic        wt_rd_en;
  logic [11:0] wt_rd_addr;
  logic        wt_data_ready;
  logic        pixel_valid;
  logic        last_pixel;
  logic        conv_valid_in;
  logic        conv_last_channel;

  int tests;
  int fails;
  int cyc;

  // scoreboard
  logic [11:0] exp_q[$];
  logic        exp_last_q[$];
  logic [11:0] obs_addr_q[$];
  int          wt_cyc_q[$];
  int          cv_cyc_q[$];
  logic        cv_last_q[$];
  int          done_cnt;
  int          bias_en_cnt;
  int          orphan_cnt;

  conv_layer_controller dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .cfg_ci_groups     (cfg_ci_groups),
    .cfg_output_group  (cfg_output_group),
    .cfg_wt_base_addr  (cfg_wt_base_addr),
    .go                (go),
    .busy              (busy),
    .done              (done),
    .bias_rd_en        (bias_rd_en),
    .bias_rd_group     (bias_rd_group),
    .bias_valid        (bias_valid),
    .wt_rd_en          (wt_rd_en),
    .wt_rd_addr        (wt_rd_addr),
    .wt_data_ready     (wt_data_ready),
    .pixel_valid       (pixel_valid),
    .last_pixel        (last_pixel),
    .conv_valid_in     (conv_valid_in),
    .conv_last_channel (conv_last_channel)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // output monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (wt_rd_en) begin
        obs_addr_q.push_back(wt_rd_addr);
        wt_cyc_q.push_back(cyc);
      end
      if (conv_valid_in) begin
        cv_cyc_q.push_back(cyc);
        cv_last_q.push_back(conv_last_channel);
      end
      if (conv_last_channel && !conv_valid_in) orphan_cnt++;
      if (done) done_cnt++;
      if (bias_rd_en) bias_en_cnt++;
    end
  end

  task automatic clear_sb();
    exp_q.delete();
    exp_last_q.delete();
    obs_addr_q.delete();
    wt_cyc_q.delete();
    cv_cyc_q.delete();
    cv_last_q.delete();
    done_cnt    = 0;
    bias_en_cnt = 0;
    orphan_cnt  = 0;
  endtask

  // driver: issue go and answer the bias read after a random delay
  task automatic start_group(input int og, input int base, input int g_cfg);
    int d;
    @(negedge clk);
    cfg_output_group = 7'(og);
    cfg_wt_base_addr = 12'(base);
    cfg_ci_groups    = 10'(g_cfg);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    tests++;
    if (bias_rd_en !== 1'b1 || busy !== 1'b1 || bias_rd_group !== 7'(og)) begin
      fails++;
      $display("FAIL start: bias_rd_en=%b busy=%b group=%0d, required 1 1 %0d",
               bias_rd_en, busy, bias_rd_group, og);
    end
    @(negedge clk);
    tests++;
    if (bias_rd_en !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL bias_wait: bias_rd_en=%b busy=%b, required 0 1", bias_rd_en, busy);
    end
    d = $urandom_range(0, 2);
    repeat (d) @(negedge clk);
    bias_valid = 1'b1;
    @(negedge clk);
    bias_valid = 1'b0;
  endtask

  // driver + reference model: beats numbered i, address base + i mod g
  task automatic send_beats(input int base, input int g, input int n,
                            input bit gaps, input bit do_last, input int go_at);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          pixel_valid = 1'b0;
          last_pixel  = 1'($urandom_range(0, 1));
          @(negedge clk);
        end
      end
      pixel_valid = 1'b1;
      last_pixel  = do_last && (i == n - 1);
      go          = (i == go_at);
      if (i == go_at) begin
        cfg_output_group = 7'($urandom_range(0, 127));
        cfg_wt_base_addr = 12'($urandom_range(0, 4095));
        cfg_ci_groups    = 10'($urandom_range(1, 9));
      end
      exp_q.push_back(12'((base + (i % g)) % 4096));
      exp_last_q.push_back((i % g) == (g - 1));
      @(negedge clk);
      go = 1'b0;
    end
    pixel_valid = 1'b0;
    last_pixel  = 1'b0;
  endtask

  task automatic finish_group();
    int k;
    k = 0;
    while (done !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    tests++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL done_timeout: done=%b after %0d cycles, required 1", done, k);
    end else begin
      tests++;
      if (busy !== 1'b0) begin
        fails++;
        $display("FAIL busy_at_done: busy=%b, required 0", busy);
      end
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL after_done: done=%b busy=%b, required 0 0", done, busy);
    end
  endtask

  task automatic check_run(input string name, input int og);
    int n;
    int shown;
    int exp_lasts;
    int got_lasts;
    shown = 0;
    exp_lasts = 0;
    got_lasts = 0;
    foreach (exp_last_q[j]) if (exp_last_q[j]) exp_lasts++;
    foreach (cv_last_q[j]) if (cv_last_q[j]) got_lasts++;

    tests++;
    if (obs_addr_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL %s wt_rd_en count: got %0d, required %0d", name, obs_addr_q.size(), exp_q.size());
    end
    n = (obs_addr_q.size() < exp_q.size()) ? obs_addr_q.size() : exp_q.size();
    for (int j = 0; j < n; j++) begin
      tests++;
      if (obs_addr_q[j] !== exp_q[j]) begin
        fails++;
        if (shown++ < 5)
          $display("FAIL %s addr[%0d]: got %0d, required %0d", name, j, obs_addr_q[j], exp_q[j]);
      end
    end

    tests++;
    if (cv_cyc_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL %s conv_valid_in count: got %0d, required %0d", name, cv_cyc_q.size(), exp_q.size());
    end
    n = (cv_cyc_q.size() < wt_cyc_q.size()) ? cv_cyc_q.size() : wt_cyc_q.size();
    for (int j = 0; j < n; j++) begin
      tests++;
      if (cv_cyc_q[j] - wt_cyc_q[j] != 3) begin
        fails++;
        if (shown++ < 5)
          $display("FAIL %s latency[%0d]: got %0d, required 3", name, j, cv_cyc_q[j] - wt_cyc_q[j]);
      end
    end
    n = (cv_last_q.size() < exp_last_q.size()) ? cv_last_q.size() : exp_last_q.size();
    for (int j = 0; j < n; j++) begin
      tests++;
      if (cv_last_q[j] !== exp_last_q[j]) begin
        fails++;
        if (shown++ < 5)
          $display("FAIL %s last_flag[%0d]: got %b, required %b", name, j, cv_last_q[j], exp_last_q[j]);
      end
    end

    tests++;
    if (got_lasts != exp_lasts || orphan_cnt != 0) begin
      fails++;
      $display("FAIL %s last_count: got %0d (orphans %0d), required %0d (orphans 0)",
               name, got_lasts, orphan_cnt, exp_lasts);
    end
    tests++;
    if (done_cnt != 1 || bias_en_cnt != 1) begin
      fails++;
      $display("FAIL %s pulses: done %0d bias_rd_en %0d, required 1 1", name, done_cnt, bias_en_cnt);
    end
    tests++;
    if (bias_rd_group !== 7'(og)) begin
      fails++;
      $display("FAIL %s group_hold: got %0d, required %0d", name, bias_rd_group, og);
    end
  endtask

  task automatic run_group(input string name, input int og, input int base,
                           input int g_cfg, input int npix, input bit gaps);
    int g;
    g = (g_cfg == 0) ? 1 : g_cfg;
    clear_sb();
    start_group(og, base, g_cfg);
    send_beats(base, g, npix * g, gaps, 1'b1, -1);
    finish_group();
    check_run(name, og);
  endtask

  task automatic check_outputs_zero(input string name);
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || bias_rd_en !== 1'b0 || bias_rd_group !== 7'd0 ||
        wt_rd_en !== 1'b0 || wt_rd_addr !== 12'd0 || conv_valid_in !== 1'b0 ||
        conv_last_channel !== 1'b0) begin
      fails++;
      $display("FAIL %s: busy=%b done=%b bias_en=%b grp=%0d wt_en=%b addr=%0d cv=%b last=%b, required all 0",
               name, busy, done, bias_rd_en, bias_rd_group, wt_rd_en, wt_rd_addr,
               conv_valid_in, conv_last_channel);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset_state");
    rst_n = 1'b1;
    @(negedge clk);
    check_outputs_zero("post_reset_idle");
  endtask

  task automatic test_idle_ignore();
    clear_sb();
    for (int i = 0; i < 6; i++) begin
      pixel_valid = 1'b1;
      last_pixel  = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    pixel_valid = 1'b0;
    last_pixel  = 1'b0;
    repeat (4) @(negedge clk);
    tests++;
    if (obs_addr_q.size() != 0 || cv_cyc_q.size() != 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL idle_ignore: wt pulses %0d cv pulses %0d busy %b, required 0 0 0",
               obs_addr_q.size(), cv_cyc_q.size(), busy);
    end
  endtask

  task automatic test_back_to_back();
    run_group("b2b_og0", 0, 0, 16, 64, 1'b0);
  endtask

  task automatic test_group_loop();
    for (int og = 0; og < 32; og++) begin
      run_group("group_loop", og, og * 16, 16, 64, 1'b0);
    end
  endtask

  task automatic test_gaps_g1();
    run_group("gaps_g1", 7, $urandom_range(0, 4095), 1, 20, 1'b1);
    run_group("g0_as_1", 3, $urandom_range(0, 4095), 0, 6, 1'b1);
  endtask

  task automatic test_addr_wrap();
    run_group("addr_wrap", 11, 4090, 16, 2, 1'b0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      run_group("random", $urandom_range(0, 127), $urandom_range(0, 4095),
                $urandom_range(1, 20), $urandom_range(1, 6), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_go_while_busy();
    clear_sb();
    start_group(21, 300, 4);
    send_beats(300, 4, 12, 1'b1, 1'b1, 5);
    finish_group();
    check_run("go_while_busy", 21);
  endtask

  task automatic test_reset_mid_conv();
    int quiet;
    clear_sb();
    start_group(9, 48, 16);
    send_beats(48, 16, 20, 1'b0, 1'b0, -1);
    pixel_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("reset_mid_conv");
    pixel_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    quiet = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (conv_valid_in !== 1'b0 || busy !== 1'b0 || done !== 1'b0) quiet++;
    end
    tests++;
    if (quiet != 0 || done_cnt != 0) begin
      fails++;
      $display("FAIL reset_abort: active cycles %0d done pulses %0d, required 0 0", quiet, done_cnt);
    end
    run_group("after_reset", 2, 32, 16, 3, 1'b0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    go = 1'b0;
    bias_valid = 1'b0;
    pixel_valid = 1'b0;
    last_pixel = 1'b0;
    wt_data_ready = 1'b0;
    cfg_ci_groups = 10'd0;
    cfg_output_group = 7'd0;
    cfg_wt_base_addr = 12'd0;
    clear_sb();

    test_reset();
    test_idle_ignore();
    test_back_to_back();
    test_group_loop();
    test_gaps_g1();
    test_addr_wrap();
    test_go_while_busy();
    test_reset_mid_conv();
    test_random();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
